// File: rtl/pes_bs_pipe.sv
// Pipelined barrel shifter: one log-shift stage per register, largest step first,
// with a valid/ready handshake that lets empty stages fill while later stages stall.
module pes_bs_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam logic [2:0] MODE_SRL = 3'd0;
  localparam logic [2:0] MODE_SLL = 3'd1;
  localparam logic [2:0] MODE_SRA = 3'd2;
  localparam logic [2:0] MODE_ROR = 3'd3;
  localparam logic [2:0] MODE_ROL = 3'd4;

  // Arithmetic shifts keep the MSB, so every SRA stage fills with the original sign bit.
  function automatic logic [WIDTH-1:0] shiftBy(input logic [WIDTH-1:0] d,
                                                input logic [2:0] mode, input int sh);
    logic [WIDTH-1:0] r;
    r = d;
    case (mode)
      MODE_SRL: r = d >> sh;
      MODE_SLL: r = d << sh;
      MODE_SRA: r = $signed(d) >>> sh;
      MODE_ROR: r = (d >> sh) | (d << (WIDTH - sh));
      MODE_ROL: r = (d << sh) | (d >> (WIDTH - sh));
      default:  r = d;
    endcase
    return r;
  endfunction

  logic [SHW-1:0]   valid_q;
  logic [SHW-1:0]   err_q;
  logic [WIDTH-1:0] data_q [SHW];
  logic [SHW-1:0]   amt_q  [SHW];
  logic [2:0]       mode_q [SHW];

  logic [SHW-1:0]   srcValid;
  logic [SHW-1:0]   srcErr;
  logic [WIDTH-1:0] srcData [SHW];
  logic [SHW-1:0]   srcAmt  [SHW];
  logic [2:0]       srcMode [SHW];

  logic [WIDTH-1:0] data_d  [SHW];
  logic [SHW-1:0]   rdy;

  for (genvar k = 0; k < SHW; k++) begin : gSrc
    if (k == 0) begin : gIn
      assign srcValid[k] = in_valid;
      assign srcData[k]  = in_data;
      assign srcAmt[k]   = in_amt;
      assign srcMode[k]  = in_mode;
      assign srcErr[k]   = (in_mode > MODE_ROL);
    end else begin : gStage
      assign srcValid[k] = valid_q[k-1];
      assign srcData[k]  = data_q[k-1];
      assign srcAmt[k]   = amt_q[k-1];
      assign srcMode[k]  = mode_q[k-1];
      assign srcErr[k]   = err_q[k-1];
    end
  end

  // Stage k can load unless it and every stage after it are full and the consumer stalls.
  always_comb begin
    rdy = '0;
    for (int k = 0; k < SHW; k++) begin
      rdy[k]    = out_ready || ((valid_q >> k) != ({SHW{1'b1}} >> k));
      data_d[k] = srcAmt[k][SHW-1-k] ? shiftBy(srcData[k], srcMode[k], 1 << (SHW-1-k))
                                     : srcData[k];
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_err   = err_q[SHW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        mode_q[k] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (rdy[k]) begin
          valid_q[k] <= srcValid[k];
          err_q[k]   <= srcErr[k];
          data_q[k]  <= data_d[k];
          amt_q[k]   <= srcAmt[k];
          mode_q[k]  <= srcMode[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pes_bs_pipe.sv
// Directed and random checks for pes_bs_pipe; expected words ride a scoreboard queue
// from the accept cycle to the retire cycle.
module tb_pes_bs_pipe;

  localparam int W   = 8;
  localparam int SHW = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [2:0]   in_amt = '0;
  logic [2:0]   in_mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_err;

  pes_bs_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           accepted = 0;
  int           retired = 0;
  logic         latOn = 1'b0;
  logic [W-1:0] curExp = '0;
  logic         curErr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent bitwise reference shifter.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int a, input int m);
    logic [W-1:0] r;
    r = d;
    if (m <= 4) begin
      for (int i = 0; i < W; i++) begin
        case (m)
          0: r[i] = (i + a < W) ? d[(i + a) % W] : 1'b0;
          1: r[i] = (i >= a) ? d[(i - a + W) % W] : 1'b0;
          2: r[i] = (i + a < W) ? d[(i + a) % W] : d[W-1];
          3: r[i] = d[(i + a) % W];
          default: r[i] = d[(i - a + W) % W];
        endcase
      end
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Push on accept, pop and compare on retire. A word presented in cycle c retires in cycle c+SHW.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back('{curExp, curErr, cyc});
        accepted++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_err", 32'(out_err), 32'(e.err));
          if (latOn) check("latency", 32'(cyc - e.acc), 32'(SHW));
          retired++;
        end
      end
      if (flush) sb.delete();
    end
  end

  task automatic applyStimulus(input logic [W-1:0] d, input int a, input int m,
                               input logic [W-1:0] exp);
    int n = 0;
    curExp   = exp;
    curErr   = (m > 4);
    in_data  = d;
    in_amt   = 3'(a);
    in_mode  = 3'(m);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendRand(input int maxMode);
    logic [W-1:0] d;
    int a, m;
    d = W'($urandom);
    a = $urandom_range(0, W - 1);
    m = $urandom_range(0, maxMode);
    applyStimulus(d, a, m, model(d, a, m));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] held;
    int           base;
    int           baseRet;
    logic         done;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, unstalled, latency checked
    latOn = 1'b1;
    applyStimulus(8'hB4, 3, 0, 8'h16);
    applyStimulus(8'hB4, 3, 1, 8'hA0);
    applyStimulus(8'hB4, 3, 3, 8'h96);
    applyStimulus(8'hB4, 2, 2, 8'hED);
    applyStimulus(8'h74, 7, 2, 8'h00);
    applyStimulus(8'h81, 1, 4, 8'h03);
    for (int m = 0; m < 8; m++) applyStimulus(8'hC3, 0, m, 8'hC3);
    applyStimulus(8'h5A, 5, 6, 8'h5A);
    applyStimulus(8'hF0, 4, 0, 8'h0F);
    drain();
    latOn = 1'b0;

    // Backpressure: 10 words, consumer stalled for 6 cycles
    out_ready = 1'b0;
    base = accepted;
    baseRet = retired;
    fork
      begin
        for (int i = 0; i < 10; i++) sendRand(4);
      end
      begin
        repeat (4) @(negedge clk);
        held = out_data;
        check("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (2) @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_accepts", 32'(accepted - base), 32'd3);
        check("bp_held", 32'(out_data), 32'(held));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_retired", 32'(retired - baseRet), 32'd10);

    // Bubble collapse: word, gap, word, then fill
    out_ready = 1'b0;
    baseRet = retired;
    applyStimulus(8'h11, 1, 0, 8'h08);
    @(negedge clk);
    check("bub_gap_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(8'h22, 1, 1, 8'h44);
    check("bub_ready_a", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bub_ready_b", 32'(in_ready), 32'd1);
    applyStimulus(8'h33, 4, 3, 8'h33);
    check("bub_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    drain();
    check("bub_retired", 32'(retired - baseRet), 32'd3);

    // Flush with a full pipeline and a word on the input
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) sendRand(4);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    flush    = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flush_no_out", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) sendRand(4);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("arst_in_ready", 32'(in_ready), 32'd1);

    // Random modes including reserved, with random consumer stalls
    done = 1'b0;
    baseRet = retired;
    fork
      begin
        for (int i = 0; i < 20; i++) sendRand(7);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("rand_retired", 32'(retired - baseRet), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
